// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: WB/EX/RA write-side signals, two read ports, scoreboard and debug access.
// The pipeline is the master; the register file is the slave.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_we;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_data;
    logic              ra_we;
    logic [DATA_W-1:0] ra_data;
    logic              rd_en1;
    logic              rd_en2;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic              rd_stall;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output wb_we, wb_addr, wb_data, ex_we, ex_addr, ex_data, ra_we, ra_data,
               rd_en1, rd_en2, rd_addr1, rd_addr2, busy_set, busy_addr, dbg_addr,
        input  rd_data1, rd_data2, rd_stall, dbg_data
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, ex_we, ex_addr, ex_data, ra_we, ra_data,
               rd_en1, rd_en2, rd_addr1, rd_addr2, busy_set, busy_addr, dbg_addr,
        output rd_data1, rd_data2, rd_stall, dbg_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// General register file with EX/WB forwarding, hardwired zero register, dedicated RA
// write port, load-use busy scoreboard and a registered debug read port.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int RA_REG   = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   bus
);
    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] RA_A   = ADDR_W'(RA_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic [ADDR_W-1:0] rd_addr [2];
    logic              rd_en   [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [1:0]        port_stall;

    assign rd_addr[0]   = bus.rd_addr1;
    assign rd_addr[1]   = bus.rd_addr2;
    assign rd_en[0]     = bus.rd_en1;
    assign rd_en[1]     = bus.rd_en2;
    assign bus.rd_data1 = rd_data[0];
    assign bus.rd_data2 = rd_data[1];
    assign bus.rd_stall = |port_stall;

    // RA commit is written after WB so it wins a same-cycle collision on RA_REG.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy         <= '0;
            bus.dbg_data <= '0;
        end else begin
            bus.dbg_data <= regs[bus.dbg_addr];
            if (bus.wb_we && bus.wb_addr != ZERO_A) begin
                regs[bus.wb_addr] <= bus.wb_data;
            end
            if (bus.ra_we && RA_A != ZERO_A) begin
                regs[RA_A] <= bus.ra_data;
            end
            if (bus.wb_we) begin
                busy[bus.wb_addr] <= 1'b0;
            end
            if (bus.busy_set) begin
                busy[bus.busy_addr] <= 1'b1;
            end
            busy[ZERO_A] <= 1'b0;
        end
    end

    // A WB commit in flight satisfies the waiting reader; EX results never do,
    // since a busy register's producer is a load that only delivers at WB.
    always_comb begin
        port_stall = '0;
        for (int p = 0; p < 2; p++) begin
            if (rd_addr[p] == ZERO_A) begin
                rd_data[p] = '0;
            end else if (bus.ex_we && bus.ex_addr == rd_addr[p]) begin
                rd_data[p] = bus.ex_data;
            end else if (bus.ra_we && rd_addr[p] == RA_A) begin
                rd_data[p] = bus.ra_data;
            end else if (bus.wb_we && bus.wb_addr == rd_addr[p]) begin
                rd_data[p] = bus.wb_data;
            end else begin
                rd_data[p] = regs[rd_addr[p]];
            end
            port_stall[p] = rd_en[p] && busy[rd_addr[p]]
                          && !(bus.wb_we && bus.wb_addr == rd_addr[p])
                          && rd_addr[p] != ZERO_A;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against a behavioural model
// of the register array, busy set and debug register.
module tb_regfile_scoreboard;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [15:0] mdl_regs [16];
    bit          mdl_busy [16];
    logic [15:0] mdl_dbg;

    regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0), .RA_REG(13)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [3:0] a);
        if (a == 4'd0)                          return 16'h0;
        if (bus.ex_we && bus.ex_addr == a)      return bus.ex_data;
        if (bus.ra_we && a == 4'd13)            return bus.ra_data;
        if (bus.wb_we && bus.wb_addr == a)      return bus.wb_data;
        return mdl_regs[a];
    endfunction

    function automatic bit exp_stall();
        bit s;
        s = 1'b0;
        if (bus.rd_en1 && mdl_busy[bus.rd_addr1] && bus.rd_addr1 != 4'd0
            && !(bus.wb_we && bus.wb_addr == bus.rd_addr1)) s = 1'b1;
        if (bus.rd_en2 && mdl_busy[bus.rd_addr2] && bus.rd_addr2 != 4'd0
            && !(bus.wb_we && bus.wb_addr == bus.rd_addr2)) s = 1'b1;
        return s;
    endfunction

    task automatic idle();
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.ex_we = 0; bus.ex_addr = 0; bus.ex_data = 0;
        bus.ra_we = 0; bus.ra_data = 0;
        bus.rd_en1 = 0; bus.rd_en2 = 0; bus.rd_addr1 = 0; bus.rd_addr2 = 0;
        bus.busy_set = 0; bus.busy_addr = 0; bus.dbg_addr = 0;
    endtask

    task automatic settle();
        #1;
        check("rd_data1", 32'(bus.rd_data1), 32'(exp_read(bus.rd_addr1)));
        check("rd_data2", 32'(bus.rd_data2), 32'(exp_read(bus.rd_addr2)));
        check("rd_stall", 32'(bus.rd_stall), 32'(exp_stall()));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            foreach (mdl_regs[i]) begin
                mdl_regs[i] = 16'h0;
                mdl_busy[i] = 1'b0;
            end
            mdl_dbg = 16'h0;
        end else begin
            mdl_dbg = mdl_regs[bus.dbg_addr];
            if (bus.wb_we && bus.wb_addr != 4'd0) mdl_regs[bus.wb_addr] = bus.wb_data;
            if (bus.ra_we) mdl_regs[13] = bus.ra_data;
            if (bus.wb_we) mdl_busy[bus.wb_addr] = 1'b0;
            if (bus.busy_set) mdl_busy[bus.busy_addr] = 1'b1;
            mdl_busy[0] = 1'b0;
        end
        #1;
        check("dbg_data", 32'(bus.dbg_data), 32'(mdl_dbg));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;

        // Everything reads back zero after reset, including every debug address.
        for (int a = 0; a < 16; a++) begin
            idle();
            bus.rd_addr1 = 4'(a); bus.rd_addr2 = 4'(15 - a); bus.dbg_addr = 4'(a);
            settle();
            check("rst_rd1_zero", 32'(bus.rd_data1), 32'h0);
            tick();
            check("rst_dbg_zero", 32'(bus.dbg_data), 32'h0);
        end

        idle(); bus.wb_we = 1; bus.wb_addr = 3; bus.wb_data = 16'h1234;
        settle(); tick();
        idle(); bus.rd_addr1 = 3;
        settle();
        check("wb_commit_r3", 32'(bus.rd_data1), 32'h1234);
        tick();

        idle(); bus.wb_we = 1; bus.wb_addr = 5; bus.wb_data = 16'h1111;
        bus.ex_we = 1; bus.ex_addr = 5; bus.ex_data = 16'h2222; bus.rd_addr1 = 5;
        settle();
        check("ex_over_wb", 32'(bus.rd_data1), 32'h2222);
        tick();
        idle(); bus.rd_addr1 = 5;
        settle();
        check("wb_commit_r5", 32'(bus.rd_data1), 32'h1111);
        tick();

        idle(); bus.wb_we = 1; bus.wb_addr = 0; bus.wb_data = 16'hFFFF;
        bus.ex_we = 1; bus.ex_addr = 0; bus.ex_data = 16'h5555; bus.rd_addr1 = 0;
        settle();
        check("zero_same", 32'(bus.rd_data1), 32'h0);
        tick();
        idle(); bus.rd_addr1 = 0; bus.dbg_addr = 0;
        settle();
        check("zero_next", 32'(bus.rd_data1), 32'h0);
        tick();
        check("zero_dbg", 32'(bus.dbg_data), 32'h0);

        idle(); bus.ra_we = 1; bus.ra_data = 16'hBEEF;
        bus.wb_we = 1; bus.wb_addr = 13; bus.wb_data = 16'h0001; bus.rd_addr2 = 13;
        settle();
        check("ra_over_wb", 32'(bus.rd_data2), 32'hBEEF);
        tick();
        idle(); bus.rd_addr2 = 13; bus.dbg_addr = 13;
        settle();
        check("ra_commit", 32'(bus.rd_data2), 32'hBEEF);
        tick();
        check("ra_dbg", 32'(bus.dbg_data), 32'hBEEF);

        idle(); bus.busy_set = 1; bus.busy_addr = 7;
        settle(); tick();
        idle(); bus.rd_en1 = 1; bus.rd_addr1 = 7;
        settle();
        check("stall_busy", 32'(bus.rd_stall), 32'h1);
        bus.ex_we = 1; bus.ex_addr = 7; bus.ex_data = 16'h0CC0;
        settle();
        check("stall_ex_no_clear", 32'(bus.rd_stall), 32'h1);
        idle(); bus.rd_en1 = 1; bus.rd_addr1 = 7;
        bus.wb_we = 1; bus.wb_addr = 7; bus.wb_data = 16'h00AA;
        settle();
        check("stall_wb_bypass", 32'(bus.rd_stall), 32'h0);
        check("wb_fwd_r7", 32'(bus.rd_data1), 32'h00AA);
        tick();
        idle(); bus.rd_en1 = 1; bus.rd_addr1 = 7;
        settle();
        check("stall_cleared", 32'(bus.rd_stall), 32'h0);
        tick();
        idle(); bus.busy_set = 1; bus.busy_addr = 7;
        bus.wb_we = 1; bus.wb_addr = 7; bus.wb_data = 16'h00BB;
        settle(); tick();
        idle(); bus.rd_en2 = 1; bus.rd_addr2 = 7;
        settle();
        check("set_beats_clear", 32'(bus.rd_stall), 32'h1);
        tick();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            bus.wb_we = 1'($urandom);     bus.wb_addr = 4'($urandom);   bus.wb_data = 16'($urandom);
            bus.ex_we = 1'($urandom);     bus.ex_addr = 4'($urandom);   bus.ex_data = 16'($urandom);
            bus.ra_we = ($urandom_range(0, 3) == 0);                  bus.ra_data = 16'($urandom);
            bus.rd_en1 = 1'($urandom);    bus.rd_en2 = 1'($urandom);
            bus.rd_addr1 = ($urandom_range(0, 3) == 0) ? 4'd13 : 4'($urandom);
            bus.rd_addr2 = 4'($urandom);
            bus.busy_set = 1'($urandom);  bus.busy_addr = 4'($urandom);
            bus.dbg_addr = 4'($urandom);
            settle();
            tick();
        end
        rst = 1'b1;

        // Reset in the middle of activity.
        for (int a = 1; a < 16; a++) begin
            idle(); bus.wb_we = 1; bus.wb_addr = 4'(a); bus.wb_data = 16'(a * 16'h0101);
            bus.busy_set = 1; bus.busy_addr = 4'(16 - a);
            settle(); tick();
        end
        idle(); bus.busy_set = 1; bus.busy_addr = 9;
        settle(); tick();
        idle(); rst = 1'b0; bus.dbg_addr = 9;
        tick();
        rst = 1'b1;
        check("mid_rst_dbg", 32'(bus.dbg_data), 32'h0);
        idle(); bus.rd_en1 = 1; bus.rd_en2 = 1; bus.rd_addr1 = 9; bus.rd_addr2 = 4; bus.dbg_addr = 4;
        settle();
        check("mid_rst_stall", 32'(bus.rd_stall), 32'h0);
        check("mid_rst_rd1", 32'(bus.rd_data1), 32'h0);
        check("mid_rst_rd2", 32'(bus.rd_data2), 32'h0);
        tick();
        check("mid_rst_dbg_next", 32'(bus.dbg_data), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the CPU's 16x16 general register file. It has a clocked commit path, combinational dual-port read, and forwarding from the EX and WB stages. A hardwired zero register and a dedicated return-address (RA) write port are included. A per-register busy scoreboard lets the decode stage generate load-use stalls. A registered debug read port replaces the flat debug bus.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, index of the hardwired zero register
RA_REG, 13, index of the return-address register written by the RA port

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
wb_we  in  1  WB-stage commit enable
wb_addr  in  ADDR_W  WB destination register
wb_data  in  DATA_W  WB write value
ex_we  in  1  EX-stage result valid (forwarding only, never commits)
ex_addr  in  ADDR_W  EX destination register
ex_data  in  DATA_W  EX result value
ra_we  in  1  RA commit enable
ra_data  in  DATA_W  value committed to RA_REG
rd_en1, rd_en2  in  1 each  read port enables (stall qualification only)
rd_addr1, rd_addr2  in  ADDR_W each  read addresses
rd_data1, rd_data2  out  DATA_W each  read data, combinational
busy_set  in  1  mark busy_addr as having an outstanding producer (load issue)
busy_addr  in  ADDR_W  register to mark busy
rd_stall  out  1  decode must stall this cycle
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  registered debug read value

Behaviour:
Reset:
- On a rising edge with rst=0, all DEPTH registers are set to 0.
- All busy bits are cleared.
- dbg_data is set to 0.
- rd_data and rd_stall are combinational; after reset they follow from the zeroed state.

Commit (rising edge, rst=1):
- If wb_we, reg[wb_addr] <= wb_data.
- If ra_we, reg[RA_REG] <= ra_data.
- ra_we and wb_we both targeting RA_REG in the same cycle: ra_data wins.
- Writes to ZERO_REG are discarded.
- ex_* never modifies the array.

Read, per port, combinational, first match wins:
- addr==ZERO_REG -> 0.
- ex_we && ex_addr==addr -> ex_data.
- ra_we && addr==RA_REG -> ra_data.
- wb_we && wb_addr==addr -> wb_data.
- Otherwise reg[addr].

Scoreboard (busy[DEPTH], rising edge):
- busy_set sets busy[busy_addr].
- wb_we clears busy[wb_addr].
- Set and clear on the same address in the same cycle: set wins (a new producer supersedes).
- busy[ZERO_REG] stays 0.
- ra_we does not touch busy bits.

Stall:
- rd_stall = OR over ports p of (rd_en_p && busy[addr_p] && !(wb_we && wb_addr==addr_p) && addr_p!=ZERO_REG).
- EX forwarding does not clear a stall; busy registers are load producers whose data arrives only at WB.

Debug:
- dbg_data <= reg[dbg_addr] every edge, 1-cycle latency.
- The array value is used, with no forwarding.

Width rules:
- All data paths are DATA_W, with no truncation or extension.
- Addresses are full ADDR_W, with no wrap handling needed.

Test Plan:
- Reset and readback: after rst=0, release, and any rd_addr, rd_data = 0x0000. Check dbg_data=0 for all 16 addresses.
- Commit and forwarding priority:
  - wb_we, addr 3, 0x1234 -> next cycle rd_data1(3)=0x1234.
  - Same cycle, wb writes 0x1111 and ex writes 0x2222, both to addr 5 -> rd_data=0x2222; after the edge, rd_data=0x1111.
- Zero register: wb_we, addr 0, 0xFFFF plus ex_we, addr 0 -> rd_data(0)=0 in both the same and the next cycle.
- RA port: ra_we 0xBEEF and wb_we 0x0001 to addr 13 in the same cycle -> combinational rd=0xBEEF; after the edge, reg13=0xBEEF.
- Scoreboard stall:
  - busy_set on addr 7, then rd_en1, rd_addr1=7 -> rd_stall=1.
  - wb_we to addr 7 with 0x00AA -> same cycle rd_stall=0 and rd_data1=0x00AA.
  - Next cycle, rd_stall stays 0.
  - Simultaneous busy_set and wb_we on addr 7 -> busy remains 1.
- Reset mid-operation: busy bits set and registers nonzero, assert rst=0 for one edge -> rd_stall=0, all reads 0, dbg_data=0 the cycle after.
